// File: rtl/mem_stage_dmem.sv
// MEM-stage data memory: byte/half/word loads and stores with wait states.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module mem_stage_dmem #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [1:0]  MEM_Size,
    input  logic        MEM_Unsigned,
    input  logic [31:0] MEM_Addr,
    input  logic [31:0] MEM_i_data,
    output logic [31:0] MEM_o_data,
    output logic        MEM_Stall,
    output logic        MEM_Done,
    output logic        MEM_Misalign
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] o_data_q, o_data_d;
    logic        misalign_q, misalign_d;

    logic [31:0] mem [DEPTH];

    logic          req;
    logic          do_wr;
    logic          do_rd;
    logic          misal;
    logic [AW-1:0] idx;
    logic [31:0]   rdata;
    logic [31:0]   rshift;
    logic [15:0]   rhalf;
    logic [31:0]   ld_val;
    logic [3:0]    be;
    logic [31:0]   wdata;

    // Upper address bits fall outside the array and wrap.
    logic unused_addr;
    assign unused_addr = ^MEM_Addr[31:AW+2];

    assign req   = MEM_MemRead | MEM_MemWrite;
    assign idx   = MEM_Addr[AW+1:2];
    assign rdata = mem[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            o_data_q   <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            o_data_q   <= o_data_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req && LAT != 4'd0) begin
                    state_d = WAIT;
                    cnt_d   = LAT - 4'd1;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        MEM_Stall = 1'b0;
        MEM_Done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                MEM_Stall = req && (LAT != 4'd0);
                MEM_Done  = req && (LAT == 4'd0);
            end
            WAIT: begin
                MEM_Stall = (cnt_q != 4'd0);
                MEM_Done  = (cnt_q == 4'd0);
            end
            default: ;
        endcase
    end

    assign do_wr = MEM_Done & MEM_MemWrite;
    assign do_rd = MEM_Done & MEM_MemRead & ~MEM_MemWrite;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misal = ((MEM_Size == 2'b01) && MEM_Addr[0]) ||
                   (MEM_Size[1] && (MEM_Addr[1:0] != 2'b00));
`else
    assign misal = 1'b0;
`endif

    always_comb begin
        be    = 4'b1111;
        wdata = MEM_i_data;
        unique case (MEM_Size)
            2'b00: begin
                be    = 4'b0001 << MEM_Addr[1:0];
                wdata = {4{MEM_i_data[7:0]}};
            end
            2'b01: begin
                be    = MEM_Addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{MEM_i_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign rshift = rdata >> {MEM_Addr[1:0], 3'b000};
    assign rhalf  = MEM_Addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        ld_val = rdata;
        unique case (MEM_Size)
            2'b00: ld_val = MEM_Unsigned ? {24'd0, rshift[7:0]}
                                         : {{24{rshift[7]}}, rshift[7:0]};
            2'b01: ld_val = MEM_Unsigned ? {16'd0, rhalf}
                                         : {{16{rhalf[15]}}, rhalf};
            default: ;
        endcase
    end

    always_comb begin
        o_data_d   = o_data_q;
        misalign_d = 1'b0;
        if (do_wr || do_rd) misalign_d = misal;
        if (do_rd)          o_data_d   = misal ? 32'd0 : ld_val;
        if (do_wr && misal) o_data_d   = 32'd0;
    end

    // Reset in the access cycle aborts the write.
    always_ff @(posedge clk) begin
        if (do_wr && !misal && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign MEM_o_data   = o_data_q;
    assign MEM_Misalign = misalign_q;

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Bench for mem_stage_dmem: three instances (LATENCY 0, 2, 3) checked every
// cycle against a transaction-level model, plus directed literal checks.
module tb_mem_stage_dmem;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic        mr [3];
    logic        mw [3];
    logic [1:0]  sz [3];
    logic        us [3];
    logic [31:0] ad [3];
    logic [31:0] di [3];
    logic [31:0] od [3];
    logic        st [3];
    logic        dn [3];
    logic        mi [3];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic int lat(input int i);
        return (i == 0) ? 0 : (i == 1) ? 2 : 3;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_stage_dmem #(
            .DEPTH  (DEPTH),
            .LATENCY((g == 0) ? 0 : (g == 1) ? 2 : 3)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .MEM_MemRead (mr[g]),
            .MEM_MemWrite(mw[g]),
            .MEM_Size    (sz[g]),
            .MEM_Unsigned(us[g]),
            .MEM_Addr    (ad[g]),
            .MEM_i_data  (di[g]),
            .MEM_o_data  (od[g]),
            .MEM_Stall   (st[g]),
            .MEM_Done    (dn[g]),
            .MEM_Misalign(mi[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: elapsed wait cycles per instance, word store keyed by instance.
    int          age   [3] = '{0, 0, 0};
    logic [31:0] m_od  [3] = '{0, 0, 0};
    logic        m_mis [3] = '{0, 0, 0};
    logic [31:0] mm [int];

    function automatic int key(input int i, input logic [31:0] a);
        return i * DEPTH + int'((a >> 2) % DEPTH);
    endfunction

    task automatic mdl_access(input int i);
        logic [31:0] a, w, v;
        logic [7:0]  b;
        logic [15:0] h;
        logic        mis;
        int          k;
        a = ad[i];
        k = key(i, a);
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = (sz[i] == 2'b01 && a[0]) || (sz[i][1] && a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        w = mm.exists(k) ? mm[k] : 32'hxxxxxxxx;
        if (mw[i]) begin
            m_mis[i] = mis;
            if (mis) m_od[i] = 32'd0;
            else begin
                case (sz[i])
                    2'b00:   w[8*a[1:0] +: 8] = di[i][7:0];
                    2'b01:   w[16*a[1] +: 16] = di[i][15:0];
                    default: w = di[i];
                endcase
                mm[k] = w;
            end
        end else if (mr[i]) begin
            m_mis[i] = mis;
            b = w[8*a[1:0] +: 8];
            h = w[16*a[1] +: 16];
            case (sz[i])
                2'b00:   v = us[i] ? {24'd0, b} : {{24{b[7]}}, b};
                2'b01:   v = us[i] ? {16'd0, h} : {{16{h[15]}}, h};
                default: v = w;
            endcase
            m_od[i] = mis ? 32'd0 : v;
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic req, e_st, e_dn;
            int n;
            n = lat(i);
            if (rst) begin
                age[i]   = 0;
                m_od[i]  = 32'd0;
                m_mis[i] = 1'b0;
            end
            req  = mr[i] | mw[i];
            e_dn = (age[i] == 0) ? (req && n == 0) : (age[i] == n);
            e_st = (age[i] == 0) ? (req && n > 0)  : (age[i] < n);
            chk($sformatf("u%0d stall", i), 32'(st[i]), 32'(e_st));
            chk($sformatf("u%0d done", i), 32'(dn[i]), 32'(e_dn));
            chk($sformatf("u%0d o_data", i), od[i], m_od[i]);
            chk($sformatf("u%0d misalign", i), 32'(mi[i]), 32'(m_mis[i]));
            if (!rst) begin
                m_mis[i] = 1'b0;
                if (e_dn) begin
                    mdl_access(i);
                    age[i] = 0;
                end else if (e_st) begin
                    age[i] = age[i] + 1;
                end
            end
        end
    end

    task automatic issue(input int i, input logic w, input logic r,
                         input logic [1:0] s, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        mw[i] = w; mr[i] = r; sz[i] = s; us[i] = u; ad[i] = a; di[i] = d;
    endtask

    task automatic finish(input int i);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!dn[i] && k < 40);
        if (!dn[i]) chk($sformatf("u%0d done timeout", i), 32'd0, 32'd1);
        @(posedge clk); #1;
        mw[i] = 1'b0; mr[i] = 1'b0;
    endtask

    task automatic acc(input int i, input logic w, input logic r,
                       input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
        issue(i, w, r, s, u, a, d);
        finish(i);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            mr[i] = 0; mw[i] = 0; sz[i] = 0; us[i] = 0; ad[i] = 0; di[i] = 0;
        end
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("reset o_data", od[i], 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // LATENCY 0 word store/load, plus address wrap
        acc(0, 1, 0, 2'b10, 0, 32'h10, 32'h12345678);
        acc(0, 0, 1, 2'b10, 0, 32'h10, 32'h0);
        chk("lw 0x10", od[0], 32'h12345678);
        acc(0, 0, 1, 2'b10, 0, 32'h10 + 4 * DEPTH, 32'h0);
        chk("lw wrap", od[0], 32'h12345678);

        // byte store into zeroed word
        acc(0, 1, 0, 2'b10, 0, 32'h20, 32'h0);
        acc(0, 1, 0, 2'b00, 0, 32'h21, 32'h000000AB);
        chk("model w20", mm[key(0, 32'h20)], 32'h0000AB00);
        acc(0, 0, 1, 2'b10, 0, 32'h20, 32'h0);
        chk("lw 0x20", od[0], 32'h0000AB00);
        acc(0, 0, 1, 2'b00, 1, 32'h21, 32'h0);
        chk("lbu 0x21", od[0], 32'h000000AB);
        acc(0, 0, 1, 2'b00, 0, 32'h21, 32'h0);
        chk("lb 0x21", od[0], 32'hFFFFFFAB);

        // halfword store preserving low lanes
        acc(0, 1, 0, 2'b10, 0, 32'h30, 32'h11223344);
        acc(0, 1, 0, 2'b01, 0, 32'h32, 32'h00008001);
        acc(0, 0, 1, 2'b01, 0, 32'h32, 32'h0);
        chk("lh 0x32", od[0], 32'hFFFF8001);
        acc(0, 0, 1, 2'b01, 1, 32'h32, 32'h0);
        chk("lhu 0x32", od[0], 32'h00008001);
        acc(0, 0, 1, 2'b11, 0, 32'h30, 32'h0);
        chk("lw size3 0x30", od[0], 32'h80013344);
        acc(0, 0, 1, 2'b01, 1, 32'h33, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("lhu 0x33", od[0], 32'h0);
`else
        chk("lhu 0x33", od[0], 32'h00008001);
`endif

        // read+write together is a write; o_data holds
        acc(0, 0, 1, 2'b10, 0, 32'h30, 32'h0);
        acc(0, 1, 1, 2'b10, 0, 32'h50, 32'h00000055);
        chk("rw hold", od[0], 32'h80013344);
        acc(0, 0, 1, 2'b00, 1, 32'h50, 32'h0);
        chk("lbu 0x50", od[0], 32'h00000055);

        // LATENCY 3 timing and back-to-back acceptance
        acc(2, 1, 0, 2'b10, 0, 32'h08, 32'hA5A5A5A5);
        issue(2, 0, 1, 2'b10, 0, 32'h08, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lat3 stall", 32'(st[2]), 32'd1);
        end
        @(negedge clk);
        chk("lat3 done", 32'(dn[2]), 32'd1);
        @(posedge clk); #1;
        chk("lat3 data", od[2], 32'hA5A5A5A5);
        issue(2, 1, 0, 2'b10, 0, 32'h0C, 32'h01020304);
        @(negedge clk);
        chk("lat3 b2b accept", 32'(st[2]), 32'd1);
        finish(2);
        acc(2, 0, 1, 2'b10, 0, 32'h0C, 32'h0);
        chk("lat3 lw 0x0C", od[2], 32'h01020304);

        // reset during WAIT aborts store
        acc(1, 1, 0, 2'b10, 0, 32'h40, 32'hDEADBEEF);
        acc(1, 0, 1, 2'b10, 0, 32'h40, 32'h0);
        issue(1, 1, 0, 2'b10, 0, 32'h40, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        mw[1] = 1'b0;
        @(negedge clk);
        chk("rst o_data", od[1], 32'h0);
        chk("rst stall", 32'(st[1]), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        acc(1, 0, 1, 2'b10, 0, 32'h40, 32'h0);
        chk("rst kept 0x40", od[1], 32'hDEADBEEF);

        // misaligned word store
        acc(0, 1, 0, 2'b10, 0, 32'h40, 32'hDEADBEEF);
        issue(0, 1, 0, 2'b10, 0, 32'h42, 32'hCAFEF00D);
        finish(0);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("misalign flag", 32'(mi[0]), 32'd1);
`else
        chk("misalign flag", 32'(mi[0]), 32'd0);
`endif
        @(posedge clk); #1;
        chk("misalign clear", 32'(mi[0]), 32'd0);
        acc(0, 0, 1, 2'b10, 0, 32'h40, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("sw 0x42 effect", od[0], 32'hDEADBEEF);
`else
        chk("sw 0x42 effect", od[0], 32'hCAFEF00D);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
